mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front-end between the core's execute stage and the `memory` block. Accepts one load/store request per transaction on a valid/ready handshake and checks SRAM alignment. Drives `memory`'s active-low `ce` transaction protocol, holding the request stable until completion, and returns a single-cycle response carrying read data and fault flags. Optionally aborts hung accesses with a watchdog.

## Interface
- `MMIO_BASE`, default 32'h00800000: addresses at or above this are MMIO and are exempt from the alignment check.
- `TIMEOUT_CYCLES`, default 4096: watchdog limit in WAIT. Only used with `MEM_ACCESS_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_write` in 1, `req_funct3` in 3, `req_addr` in 32, `req_wdata` in 32: request payload.
- `rsp_valid` out 1: response strobe, one cycle wide.
- `rsp_rdata` out 32, `rsp_fault` out 1, `rsp_misaligned` out 1, `rsp_timeout` out 1: response payload.
- `mem_ce` out 1: active low, to `memory.ce`.
- `mem_funct3` out 3, `mem_addr` out 32, `mem_datain` out 32, `mem_memwrite` out 1: registered request to `memory`.
- `mem_dataout` in 32, `mem_busy` in 1, `mem_valid` in 1, `mem_load_access_fault` in 1: status from `memory`.

## Operation
- States:
  - IDLE: `req_ready`=1, `mem_ce`=1.
  - ISSUE: `mem_ce`=0, `mem_busy` is not evaluated.
  - WAIT: `mem_ce`=0.
  - RESPOND: `rsp_valid`=1, `mem_ce`=1.
- IDLE, on `req_valid`:
  - Latch the payload into the `mem_*` registers.
  - Misaligned means `req_addr < MMIO_BASE` and either `funct3[1:0]`=01 with `addr[0]`≠0, or `funct3[1:0]`=10 with `addr[1:0]`≠0.
  - If misaligned: go to RESPOND with `rsp_misaligned`=1 and `rsp_rdata`=0; `mem_ce` is never asserted.
  - Otherwise: go to ISSUE.
- ISSUE → WAIT unconditionally. During ISSUE, `memory` samples `addr`/`memwrite` in its IDLE state.
- WAIT → RESPOND on the first cycle with `mem_busy`=0. In that cycle:
  - Capture `rsp_rdata` = `mem_dataout` for loads, 0 for stores.
  - Capture `rsp_fault` = `mem_load_access_fault`.
- Completion is decided by `mem_busy` alone, not `mem_valid`. Control-register reads finish with `mem_valid`=0.
- RESPOND → IDLE. Dropping `mem_ce` in RESPOND returns `memory` to its IDLE state at the end of that cycle, so a back-to-back request is legal.
- `mem_funct3`, `mem_memwrite` and `mem_datain` stay constant from ISSUE through RESPOND. `memory` reads live `funct3`/`memwrite` mid-transaction.
- Response flags are mutually exclusive; `rsp_rdata`=0 whenever any flag is set.
- Reset in any state:
  - Next state IDLE.
  - `mem_ce`=1, `rsp_valid`=0, all `rsp_*` and `mem_*` registers 0.
  - Any in-flight access is abandoned without a response.

## Timing
- Request accepted at cycle T.
- ISSUE at T+1; WAIT begins at T+2.
- If WAIT first sees `mem_busy`=0 at cycle D, `rsp_valid` is high at D+1.
- GPIO write: `mem_busy` is 1 at T+2 and 0 at T+3, so `rsp_valid` is at T+4 (minimum latency for a real access).
- Misaligned request: `rsp_valid` at T+1.
- `req_ready` is 1 only in IDLE, including the first cycle after reset deasserts.
- `rsp_valid` lasts exactly one cycle; there is no back-pressure on the response.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` while `mem_busy`=1: go to RESPOND with `rsp_timeout`=1 and `rsp_rdata`=0.
  - Releasing `mem_ce` aborts the access inside `memory`.
  - If `mem_busy` falls in the same cycle the counter expires, completion wins.
- `MEM_ACCESS_TIMEOUT_EN` undefined:
  - No counter; WAIT can last indefinitely.
  - `rsp_timeout` is tied to 0.

## Test plan
- Word load from SRAM addr 0x000100, model returns 0xDEADBEEF after 70 busy cycles -> one `rsp_valid`, `rsp_rdata`=0xDEADBEEF, all flags 0, `mem_ce` low for 72 cycles.
- `sw` to 0x000102 -> `rsp_valid` at T+1, `rsp_misaligned`=1, `mem_ce` never low. `lw` from 0x00800001 -> not flagged, access issued.
- GPIO write 0xA5 to 0x00800000, then an immediate back-to-back read of 0x00800001 -> first `rsp_valid` at T+4; second request accepted the following cycle; `mem_funct3`/`mem_memwrite` stable throughout each transaction.
- Load from 0x00900000, memory raises fault -> `rsp_fault`=1, `rsp_rdata`=0; next request completes normally.
- With `MEM_ACCESS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `mem_busy` held high -> `rsp_timeout`=1 exactly 16 WAIT cycles after entry, `mem_ce` high in RESPOND.
- Assert `reset` for one cycle mid-WAIT -> `mem_ce`=1 the next cycle, no `rsp_valid`, `req_ready`=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front-end to the `memory` block: alignment check, active-low ce protocol, one-cycle response.
// Optional hung-access watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
  parameter logic [31:0] MMIO_BASE      = 32'h0080_0000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  // Request: a transfer happens on a cycle with req_valid && req_ready; req_ready is high only
  // while idle, and the payload is only sampled on that cycle.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // Response: rsp_valid is a one-cycle strobe with no back-pressure.
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        rsp_misaligned,
  output logic        rsp_timeout,
  output logic        mem_ce,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_memwrite,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic        mem_load_access_fault
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t state, state_next;
  logic   misaligned;
  logic   accept;
  logic   timeout_hit;
  logic   unused_ok;

  // MMIO space is exempt; byte accesses (funct3[1:0]=00) are always aligned.
  always_comb begin
    misaligned = 1'b0;
    if (req_addr < MMIO_BASE) begin
      if (req_funct3[1:0] == 2'b01) misaligned = req_addr[0];
      else if (req_funct3[1:0] == 2'b10) misaligned = (req_addr[1:0] != 2'b00);
    end
  end

  assign accept = (state == IDLE) && req_valid;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          rsp_timeout_q;

  // Counter holds k in the k-th WAIT cycle (0-based), so expiry lands on WAIT cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) wait_cnt <= '0;
    else if (state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
  end

  // Requires mem_busy, so a completion in the expiry cycle takes precedence.
  assign timeout_hit = (state == WAIT) && mem_busy && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) rsp_timeout_q <= 1'b0;
    else if (accept) rsp_timeout_q <= 1'b0;
    else if (timeout_hit) rsp_timeout_q <= 1'b1;
  end

  assign rsp_timeout = rsp_timeout_q;
  assign unused_ok   = mem_valid;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
  assign unused_ok   = mem_valid ^ (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = misaligned ? RESPOND : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (!mem_busy || timeout_hit) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESPOND);
  assign mem_ce    = !((state == ISSUE) || (state == WAIT));

  // Request registers stay frozen from accept until the next accept; memory reads them live.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_funct3     <= 3'b000;
      mem_addr       <= 32'h0;
      mem_datain     <= 32'h0;
      mem_memwrite   <= 1'b0;
      rsp_rdata      <= 32'h0;
      rsp_fault      <= 1'b0;
      rsp_misaligned <= 1'b0;
    end else if (accept) begin
      mem_funct3     <= req_funct3;
      mem_addr       <= req_addr;
      mem_datain     <= req_wdata;
      mem_memwrite   <= req_write;
      rsp_rdata      <= 32'h0;
      rsp_fault      <= 1'b0;
      rsp_misaligned <= misaligned;
    end else if (state == WAIT && state_next == RESPOND) begin
      if (timeout_hit) begin
        rsp_rdata <= 32'h0;
        rsp_fault <= 1'b0;
      end else begin
        rsp_fault <= mem_load_access_fault;
        rsp_rdata <= (!mem_memwrite && !mem_load_access_fault) ? mem_dataout : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model, per-cycle compare process,
// behavioural memory responder and a few hand-computed directed checks.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int          TO   = 16;
  localparam logic [31:0] MMIO = 32'h0080_0000;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk, reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault, rsp_misaligned, rsp_timeout;
  logic        mem_ce, mem_memwrite;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic        mem_busy, mem_valid, mem_load_access_fault;

  mem_access_unit #(.MMIO_BASE(MMIO), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout),
    .mem_ce(mem_ce), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_datain(mem_datain), .mem_memwrite(mem_memwrite),
    .mem_dataout(mem_dataout), .mem_busy(mem_busy), .mem_valid(mem_valid),
    .mem_load_access_fault(mem_load_access_fault)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard state ----------------
  // exp_q entry: {response cycle[31:0], rdata[31:0], fault, misaligned, timeout}
  logic [66:0] exp_q[$];
  // mem_q entry: {busy WAIT cycles[7:0], read data[31:0], fault}
  logic [40:0] mem_q[$];
  int          ready_from, ce_lo_from, ce_lo_to, stab_from, stab_to;
  logic [2:0]  stab_f3;
  logic        stab_wr;
  logic [31:0] stab_addr, stab_wd;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    if (a >= MMIO) return 1'b0;
    if (f3[1:0] == 2'b01) return (a % 2) != 0;
    if (f3[1:0] == 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input logic [31:0] rd,
                        input logic flt, output int t_acc);
    int          guard;
    int          r;
    bit          mis, tmo;
    logic [31:0] er;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    t_acc = cyc;
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, guard);
      return;
    end
    mis = is_mis(f3, a);
    tmo = !mis && TMO_EN && (lat >= TO);
    if (mis) r = t_acc + 1;
    else if (tmo) r = t_acc + 2 + TO;
    else r = t_acc + 3 + lat;
    er = (mis || tmo || wr || flt) ? 32'h0 : rd;
    exp_q.push_back({32'(r), er, flt && !mis && !tmo, mis, tmo});
    if (!mis) mem_q.push_back({8'(lat), rd, flt});
    ce_lo_from = t_acc + 1;
    ce_lo_to   = mis ? t_acc : r - 1;
    stab_from  = t_acc + 1;
    stab_to    = r;
    stab_f3    = f3;
    stab_wr    = wr;
    stab_addr  = a;
    stab_wd    = wd;
    ready_from = r + 1;
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Call right after do_req returns; counts mem_ce-low cycles until the response.
  task automatic wait_rsp(output int at, output int lo);
    int guard;
    guard = 0;
    lo    = 0;
    at    = -1;
    #2;
    while (guard < 400) begin
      if (!mem_ce) lo++;
      if (rsp_valid) begin
        at = cyc;
        return;
      end
      @(posedge clk);
      #3;
      guard++;
    end
    total++;
    bad++;
    $display("FAIL rsp_wait: no rsp_valid within %0d cycles", guard);
  endtask

  // ---------------- behavioural memory ----------------
  initial begin
    logic [40:0] p;
    int          k;
    bit          active;
    p = '0; k = 0; active = 1'b0;
    mem_busy = 1'b0; mem_valid = 1'b0; mem_load_access_fault = 1'b0; mem_dataout = 32'h0;
    forever begin
      @(negedge clk);
      if (reset || mem_ce) begin
        active = 1'b0;
        mem_busy = 1'b0; mem_valid = 1'b0; mem_load_access_fault = 1'b0;
        mem_dataout = $urandom;
      end else begin
        if (!active) begin
          active = 1'b1;
          k = 0;
          p = (mem_q.size() > 0) ? mem_q.pop_front() : '0;
        end else begin
          k++;
        end
        mem_busy = (k == 0) || (k <= int'(p[40:33]));
        if (mem_busy) begin
          mem_dataout = $urandom; mem_valid = 1'b0; mem_load_access_fault = 1'b0;
        end else begin
          mem_dataout = p[32:1]; mem_load_access_fault = p[0]; mem_valid = !p[0];
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [66:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        chk("req_ready", 32'(req_ready), 32'(cyc >= ready_from));
        chk("mem_ce", 32'(mem_ce), 32'(!(cyc >= ce_lo_from && cyc <= ce_lo_to)));
        if (cyc >= stab_from && cyc <= stab_to) begin
          chk("mem_funct3", 32'(mem_funct3), 32'(stab_f3));
          chk("mem_memwrite", 32'(mem_memwrite), 32'(stab_wr));
          chk("mem_addr", mem_addr, stab_addr);
          chk("mem_datain", mem_datain, stab_wd);
        end
        if (exp_q.size() > 0 && int'(exp_q[0][66:35]) < cyc) begin
          total++;
          bad++;
          $display("FAIL rsp_missing: rsp_valid=0 at cycle %0d, required 1", int'(exp_q[0][66:35]));
          void'(exp_q.pop_front());
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required 0", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_cycle", 32'(cyc), e[66:35]);
            chk("rsp_rdata", rsp_rdata, e[34:3]);
            chk("rsp_fault", 32'(rsp_fault), 32'(e[2]));
            chk("rsp_misaligned", 32'(rsp_misaligned), 32'(e[1]));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e[0]));
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int t, t2, r, lo;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    ready_from = 0; ce_lo_from = 1; ce_lo_to = 0; stab_from = 1; stab_to = 0;
    stab_f3 = 3'b000; stab_wr = 1'b0; stab_addr = 32'h0; stab_wd = 32'h0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_mem_ce", 32'(mem_ce), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_funct3", 32'(mem_funct3), 32'd0);
    chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ready_from = cyc;
    chk_en = 1'b1;

`ifndef MEM_ACCESS_TIMEOUT_EN
    // Word load, 70 busy cycles.
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 70, 32'hDEAD_BEEF, 1'b0, t);
    wait_rsp(r, lo);
    chk("lw_latency", 32'(r - t), 32'd73);
    chk("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("lw_ce_low_cycles", 32'(lo), 32'd72);
`else
    // Hung load, aborted by the watchdog.
    do_req(1'b0, 3'b010, 32'h0000_0200, 32'h0, 100, 32'h1234_5678, 1'b0, t);
    wait_rsp(r, lo);
    chk("tmo_latency", 32'(r - t), 32'd18);
    chk("tmo_flag", 32'(rsp_timeout), 32'd1);
    chk("tmo_rdata", rsp_rdata, 32'h0);
    chk("tmo_ce_respond", 32'(mem_ce), 32'd1);
    chk("tmo_ce_low_cycles", 32'(lo), 32'd17);
`endif

    // Misaligned store, then MMIO word load with an odd address.
    do_req(1'b1, 3'b010, 32'h0000_0102, 32'h1111_1111, 0, 32'h0, 1'b0, t);
    wait_rsp(r, lo);
    chk("sw_mis_latency", 32'(r - t), 32'd1);
    chk("sw_mis_flag", 32'(rsp_misaligned), 32'd1);
    chk("sw_mis_ce_low", 32'(lo), 32'd0);
    do_req(1'b0, 3'b010, 32'h0080_0001, 32'h0, 3, 32'h1234_5678, 1'b0, t);
    wait_rsp(r, lo);
    chk("mmio_lw_flag", 32'(rsp_misaligned), 32'd0);
    chk("mmio_lw_rdata", rsp_rdata, 32'h1234_5678);

    // GPIO write then back-to-back read.
    do_req(1'b1, 3'b000, 32'h0080_0000, 32'h0000_00A5, 1, $urandom, 1'b0, t);
    wait_rsp(r, lo);
    chk("gpio_wr_latency", 32'(r - t), 32'd4);
    do_req(1'b0, 3'b100, 32'h0080_0001, 32'h0, 1, 32'h0000_005A, 1'b0, t2);
    chk("b2b_accept", 32'(t2 - r), 32'd1);
    wait_rsp(r, lo);
    chk("gpio_rd_rdata", rsp_rdata, 32'h0000_005A);

    // Faulting load followed by a clean one.
    do_req(1'b0, 3'b010, 32'h0090_0000, 32'h0, 2, 32'hCAFE_F00D, 1'b1, t);
    wait_rsp(r, lo);
    chk("fault_flag", 32'(rsp_fault), 32'd1);
    chk("fault_rdata", rsp_rdata, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_0104, 32'h0, 2, 32'h0BAD_F00D, 1'b0, t);
    wait_rsp(r, lo);
    chk("post_fault_flag", 32'(rsp_fault), 32'd0);
    chk("post_fault_rdata", rsp_rdata, 32'h0BAD_F00D);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          lat;
      logic        wr, flt;
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 32'h007F_FFFF));
      else a = MMIO + 32'($urandom_range(0, 255));
      wr = 1'($urandom_range(0, 1));
      flt = !wr && ($urandom_range(0, 7) == 0);
`ifdef MEM_ACCESS_TIMEOUT_EN
      lat = $urandom_range(12, 20);
`else
      lat = $urandom_range(0, 20);
`endif
      do_req(wr, f3, a, $urandom, lat, $urandom, flt, t);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    chk("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of WAIT abandons the access.
    do_req(1'b0, 3'b010, 32'h0000_0300, 32'h0, 50, $urandom, 1'b0, t);
    repeat (5) @(negedge clk);
    chk("pre_reset_in_wait", 32'(mem_ce), 32'd0);
    reset  = 1'b1;
    chk_en = 1'b0;
    @(posedge clk);
    #3;
    chk("midreset_mem_ce", 32'(mem_ce), 32'd1);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    mem_q.delete();
    ce_lo_from = 1; ce_lo_to = 0; stab_from = 1; stab_to = 0;
    ready_from = cyc;
    chk_en = 1'b1;
    @(posedge clk);
    #3;
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
